// File: rtl/lsu.sv
// Load/store stage: one instruction in flight, aligns and masks data-memory
// accesses, extends load data, and emits one writeback record per instruction.
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_ren,
  input  logic            mem_wen,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic            reg_wen_ex,
  input  logic [4:0]      rd_ex,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wmask,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            ls_valid,
  input  logic            ls_ready,
  output logic [XLEN-1:0] pc_ls,
  output logic [4:0]      rd_ls,
  output logic            reg_wen_ls,
  output logic [XLEN-1:0] reg_wdata_ls,
  output logic            misalign_ls
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            ex_ready_q, ex_ready_d;
  logic            req_valid_q, req_valid_d;
  logic            ls_valid_q, ls_valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_wen_q, reg_wen_d;
  logic [XLEN-1:0] reg_wdata_q, reg_wdata_d;
  logic            misalign_q, misalign_d;
  logic            is_load_q, is_load_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;

  logic [1:0]      off_in;
  logic            is_mem, misaligned;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;

  assign off_in     = alu_result[1:0];
  assign is_mem     = mem_ren | mem_wen;
  assign misaligned = ((mem_size == 2'd1) && off_in[0]) || (mem_size[1] && (off_in != 2'd0));

  // Lane extraction and extension of the returned read word
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'd0:    ld_val = {{(XLEN-8){ld_byte[7] & ~uns_q}}, ld_byte};
      2'd1:    ld_val = {{(XLEN-16){ld_half[15] & ~uns_q}}, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_wen_d   = reg_wen_q;
    reg_wdata_d = reg_wdata_q;
    misalign_d  = misalign_q;
    is_load_d   = is_load_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          pc_d        = pc_ex;
          rd_d        = rd_ex;
          reg_wdata_d = alu_result;
          misalign_d  = 1'b0;
          reg_wen_d   = reg_wen_ex & ~(is_mem & (mem_wen | misaligned));
          if (!is_mem) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d   = S_REQ;
            addr_d    = {alu_result[XLEN-1:2], 2'b00};
            wen_d     = mem_wen;
            is_load_d = ~mem_wen;
            size_d    = mem_size;
            uns_d     = mem_unsigned;
            off_d     = off_in;
            case (mem_size)
              2'd0: begin
                wdata_d = {4{store_data[7:0]}};
                wmask_d = 4'(4'b0001 << off_in);
              end
              2'd1: begin
                wdata_d = {2{store_data[15:0]}};
                wmask_d = 4'(4'b0011 << off_in);
              end
              default: begin
                wdata_d = store_data;
                wmask_d = 4'b1111;
              end
            endcase
          end
        end
      end
      S_REQ:      if (dmem_req_ready) state_d = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          state_d = S_DONE;
          if (is_load_q) reg_wdata_d = ld_val;
        end
      end
      S_DONE:     if (ls_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    ex_ready_d  = (state_d == S_IDLE);
    req_valid_d = (state_d == S_REQ);
    ls_valid_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ex_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      ls_valid_q  <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_wen_q   <= 1'b0;
      reg_wdata_q <= '0;
      misalign_q  <= 1'b0;
      is_load_q   <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= ex_ready_d;
      req_valid_q <= req_valid_d;
      ls_valid_q  <= ls_valid_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_wen_q   <= reg_wen_d;
      reg_wdata_q <= reg_wdata_d;
      misalign_q  <= misalign_d;
      is_load_q   <= is_load_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
    end
  end

  assign ex_ready       = ex_ready_q;
  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = addr_q;
  assign dmem_wen       = wen_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wmask     = wmask_q;
  assign ls_valid       = ls_valid_q;
  assign pc_ls          = pc_q;
  assign rd_ls          = rd_q;
  assign reg_wen_ls     = reg_wen_q;
  assign reg_wdata_ls   = reg_wdata_q;
  assign misalign_ls    = misalign_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store stage sitting directly downstream of the execute stage in the npc core. It accepts one instruction at a time from the execute stage over a valid/ready handshake and performs the data-memory access for loads and stores: byte-lane alignment, write masking and load sign/zero extension. Non-memory instructions pass their ALU result straight through. It hands one writeback record per instruction to the writeback stage.

## Interface
- XLEN, 32, data and address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  lsu can accept (high only in IDLE)
- pc_ex  in  XLEN  instruction PC
- alu_result  in  XLEN  memory address for loads/stores, writeback data otherwise
- store_data  in  XLEN  rs2 value for stores
- mem_ren / mem_wen  in  1 each  load / store
- mem_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- mem_unsigned  in  1  zero-extend load (lbu/lhu)
- reg_wen_ex  in  1  instruction writes rd
- rd_ex  in  5  destination register
- dmem_req_valid  out  1  memory request
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  XLEN  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wen  out  1  request is a write
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wmask  out  4  byte write strobes
- dmem_rsp_valid  in  1  read data / write ack, one cycle pulse
- dmem_rdata  in  XLEN  read word
- ls_valid  out  1  writeback record valid
- ls_ready  in  1  writeback stage accepts
- pc_ls  out  XLEN, rd_ls  out  5, reg_wen_ls  out  1, reg_wdata_ls  out  XLEN  writeback record
- misalign_ls  out  1  access was misaligned, no memory access performed

## Operation
- FSM states IDLE, REQ, WAIT_RSP, DONE. Reset → IDLE.
- IDLE: ex_ready=1. On ex_valid, latch all ex inputs. Then:
  - no memory op → DONE, reg_wdata_ls=alu_result.
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0) → DONE, misalign_ls=1, reg_wen_ls=0.
  - otherwise → REQ.
- mem_ren and mem_wen both high: treated as store, ren ignored.
- REQ: dmem_req_valid=1 with stable addr/wen/wdata/wmask. On dmem_req_ready → WAIT_RSP.
- WAIT_RSP: on dmem_rsp_valid → DONE. For loads, reg_wdata_ls is captured from dmem_rdata. Stores ignore rdata.
- DONE: ls_valid=1, record stable. On ls_ready → IDLE.
- Store formatting (off=addr[1:0]):
  - byte: wdata={4{sd[7:0]}}, wmask=4'b0001<<off.
  - half: wdata={2{sd[15:0]}}, wmask=4'b0011<<off.
  - word: wdata=sd, wmask=4'b1111.
- Load extraction:
  - byte: dmem_rdata[8*off+:8].
  - half: dmem_rdata[16*off[1]+:16].
  - Sign-extended unless mem_unsigned.
- Stores force reg_wen_ls=0. Loads and ALU ops pass reg_wen_ex/rd_ex unchanged.
- dmem_rsp_valid outside WAIT_RSP is ignored. dmem_req_ready outside REQ is ignored.

## Timing
- Reset value of every output:
  - ex_ready=1.
  - dmem_req_valid=0, dmem_wen=0, dmem_addr=0, dmem_wdata=0, dmem_wmask=0.
  - ls_valid=0, pc_ls=0, rd_ls=0, reg_wen_ls=0, reg_wdata_ls=0, misalign_ls=0.
- Non-memory or misaligned op: accepted at cycle 0, ls_valid high from cycle 1.
- Memory op: accepted at cycle 0, dmem_req_valid from cycle 1. With ready at cycle r and rsp at cycle n>r, ls_valid is high from cycle n+1. Minimum latency is 3 cycles (r=1, n=2).
- Response in the same cycle as request acceptance is not supported. Memory guarantees n>r.
- One instruction in flight. ex_ready=0 in REQ, WAIT_RSP and DONE, so no overlap with the next accept.
- ls_valid is held with a stable record until ls_ready. Back-pressure of any length is allowed.
- Reset asserted mid-transaction aborts to IDLE immediately. A late response arriving after reset is dropped.

## Test plan
- ALU passthrough:
  - Stimulus: alu_result=0x1234_5678, reg_wen_ex=1, rd=5, ls_ready=1.
  - Required: ls_valid at cycle 1, reg_wdata_ls=0x1234_5678, reg_wen_ls=1, rd_ls=5, no dmem_req_valid.
- Signed byte load:
  - Stimulus: addr=0x8000_0003, size=0, unsigned=0, rdata=0x80FF_0011.
  - Required: dmem_addr=0x8000_0000, reg_wdata_ls=0xFFFF_FF80. Repeated with unsigned=1 → 0x0000_0080.
- Half store:
  - Stimulus: addr=0x8000_0002, size=1, store_data=0xAAAA_BEEF.
  - Required: dmem_wen=1, wdata=0xBEEF_BEEF, wmask=4'b1100, reg_wen_ls=0.
- Misaligned word load:
  - Stimulus: addr=0x8000_0001.
  - Required: no dmem request, ls_valid at cycle 1, misalign_ls=1, reg_wen_ls=0.
- Stalls:
  - Stimulus: dmem_req_ready low for 3 cycles, rsp 4 cycles later, ls_ready low for 2 cycles.
  - Required: request fields stable throughout REQ, ex_ready=0 until the handshake completes, record unchanged during back-pressure.
- Reset in WAIT_RSP:
  - Stimulus: rst asserted in WAIT_RSP, then a response pulse after release.
  - Required: all outputs at reset values, ex_ready=1, stray response produces no ls_valid.
